// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding imem read at a time; each returned word is buffered with its PC for decode.
// Latency: grant to inst_valid is at least 2 cycles. Requests stall while the buffer is full, during a flush, or on a misaligned PC.
module instr_fetch_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int BUF_DEPTH  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] pc,
   output logic                  pc_advance,
   input  logic                  flush,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_gnt,
   input  logic                  imem_rvalid,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic                  inst_valid,
   output logic [DATA_WIDTH-1:0] inst,
   output logic [ADDR_WIDTH-1:0] inst_pc,
   input  logic                  inst_ready,
   output logic                  fetch_err
);

   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] req_pc;
   logic [DATA_WIDTH-1:0] buf_dat [BUF_DEPTH];
   logic [ADDR_WIDTH-1:0] buf_pc  [BUF_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  pc_aligned;
   logic                  grant;
   logic                  push;
   logic                  pop;

   // Credit check uses the registered count: a same-cycle pop does not free a slot.
   assign pc_aligned = (pc[1:0] == 2'b00);
   assign imem_req   = (state == REQ) && !flush && pc_aligned && (count < CNT_W'(BUF_DEPTH));
   assign imem_addr  = pc;
   assign grant      = imem_req && imem_gnt;
   assign pc_advance = grant;

   assign push = (state == WAIT) && imem_rvalid && !flush;
   assign pop  = inst_valid && inst_ready;

   assign inst_valid = (count != '0);
   assign inst       = buf_dat[rd_ptr];
   assign inst_pc    = buf_pc[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         req_pc    <= '0;
         fetch_err <= 1'b0;
      end else begin
         if (flush)
            fetch_err <= 1'b0;
         else if ((state == REQ) && !pc_aligned)
            fetch_err <= 1'b1;

         case (state)
            IDLE: state <= REQ;
            REQ: begin
               if (grant) begin
                  req_pc <= pc;
                  state  <= WAIT;
               end
            end
            // A flush without data leaves one response in flight that must be swallowed.
            WAIT: begin
               if (imem_rvalid)
                  state <= REQ;
               else if (flush)
                  state <= DROP;
            end
            DROP: begin
               if (imem_rvalid)
                  state <= REQ;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            buf_dat[i] <= '0;
            buf_pc[i]  <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            buf_dat[wr_ptr] <= imem_rdata;
            buf_pc[wr_ptr]  <= req_pc;
            wr_ptr          <= wr_ptr + PTR_W'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)
            count <= count + CNT_W'(1);
         else if (!push && pop)
            count <= count - CNT_W'(1);
      end
   end

endmodule
